ps2_init_sequencer: RTL
=======================

// Module: ps2_init_sequencer
// PURPOSE
//  Command/configuration controller between PS2_Controller and game logic. On start it
//  resets the keyboard (FF, ACK FA, BAT AA), then sets typematic rate (F3+rate), LEDs
//  (ED+leds) and enables scanning (F4), with ACK checks, FE-resend retries and timeouts.
//  Once READY it forwards scancodes and sequences LED updates on request.
// PARAMETERS
//  ACK_TIMEOUT  2_500_000   cycles allowed for FA after each byte sent (50 ms @ 50 MHz)
//  BAT_TIMEOUT  50_000_000  cycles allowed for AA after reset ACK (1 s @ 50 MHz)
//  MAX_RETRY    3           resends of one byte (FE or ack timeout) before FAIL
// PORTS
//  CLOCK_50              in   1  system clock, all logic on rising edge
//  reset                 in   1  synchronous, active-high
//  start                 in   1  pulse: begin full init (accepted in IDLE or FAIL only)
//  rate_cfg              in   8  typematic byte sent after F3, sampled at start
//  led_cfg               in   3  {caps,num,scroll}, sampled when the ED/LED step begins
//  led_update            in   1  pulse: request LED resend (honoured in READY)
//  received_data         in   8  byte from PS2_Controller
//  received_data_en      in   1  1-cycle strobe, received_data valid
//  command_was_sent      in   1  1-cycle strobe: byte shifted out
//  error_communication_timed_out in 1  1-cycle strobe: transmit failed
//  command_to_send       out  8  byte to PS2_Controller
//  send_command          out  1  transmit request (level)
//  key_data              out  8  forwarded scancode byte
//  key_valid             out  1  1-cycle strobe with key_data
//  ready                 out  1  high in READY only
//  busy                  out  1  high in SEND/WAIT_ACK/WAIT_BAT
//  fail                  out  1  high in FAIL only
//  fail_code             out  2  01 ack timeout/retries, 10 BAT timeout, 11 BAT error FC
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; step=0, retry=0, timer=0, led_pending=0.
//  Step table: 0 FF, 1 F3, 2 rate_cfg, 3 ED, 4 {5'b0,led_cfg}, 5 F4.
//  IDLE/FAIL -start-> SEND step 0; retry=0, fail_code=0. start elsewhere ignored.
//  SEND: command_to_send=table[step], send_command=1 from first SEND cycle until
//   command_was_sent (-> WAIT_ACK, timer=0) or error strobe (counts as retry). Both
//   together: error wins. Received bytes in SEND dropped.
//  WAIT_ACK: timer++ each cycle. FA -> if step 0 -> WAIT_BAT (timer=0); else NEXT.
//   FE or timer==ACK_TIMEOUT-1 -> retry++, back to SEND same step; retry reaching
//   MAX_RETRY -> FAIL code 01. Other bytes ignored.
//  WAIT_BAT: AA -> step 1, SEND. FC -> FAIL 11. timer==BAT_TIMEOUT-1 -> FAIL 10.
//  NEXT (combinational decision, no extra cycle): retry=0; step 5 done, or step 4 done in
//   LED-update mode -> READY; else step+1, SEND.
//  READY: received_data_en -> key_data<=received_data, key_valid=1 next cycle (1-cycle
//   latency). led_update or led_pending -> step 3, SEND, LED-update mode, pending cleared.
//  led_update outside READY sets led_pending (one outstanding request, no count).
//  Key bytes never forwarded outside READY. timer width $clog2(BAT_TIMEOUT), saturates.
//  reset mid-sequence: send_command drops on the reset edge, partial config discarded.
// TESTING
//  1 start, model replies FA@cs, AA, then FA to F3,rate=0x20,ED,0x02,F4 -> bytes out in that
//    order, ready=1 one cycle after last FA, busy=0.
//  2 Model replies FE to F3 twice, then FA -> F3 sent 3 times, sequence completes, ready=1.
//  3 No ACK to FF (ACK_TIMEOUT=100 in bench) -> FF sent 4 times total, fail=1, fail_code=01.
//  4 After FF ACK reply FC -> fail=1 code 11; start again -> FF resent, fail clears.
//  5 In READY, received_data_en with 0x1C -> key_valid 1 cycle, key_data=0x1C; led_update
//    with led_cfg=3'b100 -> ED,0x04 sent, ready low meanwhile, back to READY, no F4.
//  6 Assert reset while send_command=1 mid step 2 -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/ps2_init_sequencer.sv
// ps2_init_sequencer
//   Sits between a PS/2 byte controller and the game logic. A start pulse runs
//   the keyboard bring-up: reset (FF, expect ACK FA, then BAT pass AA), set
//   the typematic rate (F3 + rate), set the LEDs (ED + leds) and enable
//   scanning (F4). Every byte needs an ACK. An FE reply, a missing ACK or a
//   transmit error makes it resend the byte, up to MAX_RETRY times. Once
//   READY it forwards scancode bytes and resends the LED setting when asked.
// Ports
//   CLOCK_50, reset                   clock, synchronous active-high reset
//   start, rate_cfg, led_cfg          init request and configuration bytes
//   led_update                        LED resend request
//   received_data(_en)                bytes coming from the keyboard
//   command_was_sent, error_communication_timed_out  transmit status strobes
//   command_to_send, send_command     byte and transmit request to controller
//   key_data, key_valid               forwarded scancode strobe
//   ready, busy, fail, fail_code      sequencer status
module ps2_init_sequencer #(
   parameter int ACK_TIMEOUT = 2_500_000,
   parameter int BAT_TIMEOUT = 50_000_000,
   parameter int MAX_RETRY   = 3
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] rate_cfg,
   input  logic [2:0] led_cfg,
   input  logic       led_update,
   input  logic [7:0] received_data,
   input  logic       received_data_en,
   input  logic       command_was_sent,
   input  logic       error_communication_timed_out,
   output logic [7:0] command_to_send,
   output logic       send_command,
   output logic [7:0] key_data,
   output logic       key_valid,
   output logic       ready,
   output logic       busy,
   output logic       fail,
   output logic [1:0] fail_code
);

   localparam int TW = $clog2(BAT_TIMEOUT);
   localparam int RW = $clog2(MAX_RETRY + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SEND     = 3'd1,
      S_WAIT_ACK = 3'd2,
      S_WAIT_BAT = 3'd3,
      S_READY    = 3'd4,
      S_FAIL     = 3'd5
   } state_t;

   state_t        state_r, state_next_s;
   logic [2:0]    step_r, step_next_s;
   logic [RW-1:0] retry_r, retry_next_s;
   logic [TW-1:0] timer_r, timer_next_s, timer_inc_s;
   logic [1:0]    fail_code_next_s;
   logic          led_mode_r, led_mode_next_s;
   logic          led_pending_r, led_pending_next_s;
   logic [7:0]    rate_r;
   logic [2:0]    led_r;
   logic          load_rate_s, load_led_s;
   logic          got_fa_s, got_fe_s;

   // Byte to transmit for each step of the bring-up sequence.
   function automatic logic [7:0] step_byte(input logic [2:0] step,
                                            input logic [7:0] rate,
                                            input logic [2:0] leds);
      case (step)
         3'd0:    step_byte = 8'hFF;
         3'd1:    step_byte = 8'hF3;
         3'd2:    step_byte = rate;
         3'd3:    step_byte = 8'hED;
         3'd4:    step_byte = {5'b00000, leds};
         3'd5:    step_byte = 8'hF4;
         default: step_byte = 8'h00;
      endcase
   endfunction

   assign timer_inc_s = (timer_r == {TW{1'b1}}) ? timer_r : timer_r + TW'(1);
   assign got_fa_s    = received_data_en && (received_data == 8'hFA);
   assign got_fe_s    = received_data_en && (received_data == 8'hFE);

   // Next-state, step/retry/timer bookkeeping.
   always_comb begin
      state_next_s       = state_r;
      step_next_s        = step_r;
      retry_next_s       = retry_r;
      timer_next_s       = timer_r;
      fail_code_next_s   = fail_code;
      led_mode_next_s    = led_mode_r;
      led_pending_next_s = led_pending_r;
      load_rate_s        = 1'b0;
      load_led_s         = 1'b0;

      // One outstanding LED request is remembered while not READY.
      if (led_update && (state_r != S_READY)) begin
         led_pending_next_s = 1'b1;
      end else begin
         led_pending_next_s = led_pending_r;
      end

      case (state_r)
         S_IDLE, S_FAIL: begin
            if (start) begin
               state_next_s     = S_SEND;
               step_next_s      = 3'd0;
               retry_next_s     = {RW{1'b0}};
               fail_code_next_s = 2'b00;
               led_mode_next_s  = 1'b0;
               load_rate_s      = 1'b1;
            end else begin
               state_next_s = state_r;
            end
         end
         S_SEND: begin
            // A transmit error wins over a simultaneous sent strobe.
            if (error_communication_timed_out) begin
               if (retry_r == RW'(MAX_RETRY)) begin
                  state_next_s     = S_FAIL;
                  fail_code_next_s = 2'b01;
               end else begin
                  retry_next_s = retry_r + RW'(1);
               end
            end else if (command_was_sent) begin
               state_next_s = S_WAIT_ACK;
               timer_next_s = {TW{1'b0}};
            end else begin
               state_next_s = S_SEND;
            end
         end
         S_WAIT_ACK: begin
            timer_next_s = timer_inc_s;
            if (got_fa_s) begin
               if (step_r == 3'd0) begin
                  state_next_s = S_WAIT_BAT;
                  timer_next_s = {TW{1'b0}};
               end else begin
                  retry_next_s = {RW{1'b0}};
                  if ((step_r == 3'd5) || ((step_r == 3'd4) && led_mode_r)) begin
                     state_next_s = S_READY;
                  end else begin
                     state_next_s = S_SEND;
                     step_next_s  = step_r + 3'd1;
                     load_led_s   = (step_r == 3'd2);
                  end
               end
            end else if (got_fe_s || (timer_r == TW'(ACK_TIMEOUT - 1))) begin
               if (retry_r == RW'(MAX_RETRY)) begin
                  state_next_s     = S_FAIL;
                  fail_code_next_s = 2'b01;
               end else begin
                  state_next_s = S_SEND;
                  retry_next_s = retry_r + RW'(1);
               end
            end else begin
               state_next_s = S_WAIT_ACK;
            end
         end
         S_WAIT_BAT: begin
            timer_next_s = timer_inc_s;
            if (received_data_en && (received_data == 8'hAA)) begin
               state_next_s = S_SEND;
               step_next_s  = 3'd1;
               retry_next_s = {RW{1'b0}};
            end else if (received_data_en && (received_data == 8'hFC)) begin
               state_next_s     = S_FAIL;
               fail_code_next_s = 2'b11;
            end else if (timer_r == TW'(BAT_TIMEOUT - 1)) begin
               state_next_s     = S_FAIL;
               fail_code_next_s = 2'b10;
            end else begin
               state_next_s = S_WAIT_BAT;
            end
         end
         S_READY: begin
            if (led_update || led_pending_r) begin
               state_next_s       = S_SEND;
               step_next_s        = 3'd3;
               retry_next_s       = {RW{1'b0}};
               led_mode_next_s    = 1'b1;
               led_pending_next_s = 1'b0;
               load_led_s         = 1'b1;
            end else begin
               state_next_s = S_READY;
            end
         end
         default: begin
            state_next_s = S_IDLE;
         end
      endcase
   end

   // Sequencer state and captured configuration.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_r       <= S_IDLE;
         step_r        <= 3'd0;
         retry_r       <= {RW{1'b0}};
         timer_r       <= {TW{1'b0}};
         led_mode_r    <= 1'b0;
         led_pending_r <= 1'b0;
         rate_r        <= 8'h00;
         led_r         <= 3'b000;
      end else begin
         state_r       <= state_next_s;
         step_r        <= step_next_s;
         retry_r       <= retry_next_s;
         timer_r       <= timer_next_s;
         led_mode_r    <= led_mode_next_s;
         led_pending_r <= led_pending_next_s;
         rate_r        <= load_rate_s ? rate_cfg : rate_r;
         led_r         <= load_led_s ? led_cfg : led_r;
      end
   end

   // Registered outputs, decoded from the next state so they line up with it.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         command_to_send <= 8'h00;
         send_command    <= 1'b0;
         key_data        <= 8'h00;
         key_valid       <= 1'b0;
         ready           <= 1'b0;
         busy            <= 1'b0;
         fail            <= 1'b0;
         fail_code       <= 2'b00;
      end else begin
         send_command    <= (state_next_s == S_SEND);
         command_to_send <= (state_next_s == S_SEND) ?
                            step_byte(step_next_s, rate_r, led_r) : 8'h00;
         key_valid       <= (state_r == S_READY) && received_data_en;
         key_data        <= ((state_r == S_READY) && received_data_en) ?
                            received_data : key_data;
         ready           <= (state_next_s == S_READY);
         busy            <= (state_next_s == S_SEND) || (state_next_s == S_WAIT_ACK) ||
                            (state_next_s == S_WAIT_BAT);
         fail            <= (state_next_s == S_FAIL);
         fail_code       <= fail_code_next_s;
      end
   end

endmodule
